// File: rtl/stall_req_unit.sv
// Hazard and stall request generator for the 4-stage IF/ID/EX/WB pipeline.
// The four *_req bits feed the downstream OR gate that forms the global stall;
// the unit also drives the per-stage write-enable, bubble and flush controls
// and keeps a saturating count of stalled cycles for performance debug.
module stall_req_unit #(
    parameter int unsigned MULT_CYCLES = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [4:0]       i_id_rs,
    input  logic [4:0]       i_id_rt,
    input  logic             i_id_uses_rt,
    input  logic [4:0]       i_ex_rd,
    input  logic             i_ex_mem_read,
    input  logic             i_ex_mult_start,
    input  logic             i_ex_branch_taken,
    input  logic             i_mem_req,
    input  logic             i_mem_ready,
    output logic             o_load_use_req,
    output logic             o_mult_busy_req,
    output logic             o_mem_wait_req,
    output logic             o_branch_flush_req,
    output logic             o_pc_write,
    output logic             o_ifid_write,
    output logic             o_idex_bubble,
    output logic             o_ifid_flush,
    output logic [CNT_W-1:0] o_stall_cycles
);

    typedef enum logic [0:0] {
        StIdle,
        StMult
    } state_e;

    // The start cycle is the first multiply cycle, so the counter covers the rest.
    localparam logic [3:0] MultLoad = 4'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    state_e           r_state;
    state_e           w_state_next;
    logic [3:0]       r_mult_cnt;
    logic [3:0]       w_mult_cnt_next;
    logic             r_branch_pending;
    logic             w_branch_pending_next;
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] w_stall_cycles_next;

    logic w_hz;
    logic w_mem_wait;
    logic w_mult_busy;
    logic w_hold;
    logic w_branch_flush;
    logic w_load_use;
    logic w_stall;
    logic w_any_req;

    // Request decode; reset forces every request low so the controls sit at
    // their reset values while reset is applied, even if state is still unknown.
    always_comb begin
        w_hz = i_ex_mem_read && (i_ex_rd != 5'd0) &&
               ((i_ex_rd == i_id_rs) || (i_id_uses_rt && (i_ex_rd == i_id_rt)));
        w_mem_wait     = !i_reset && i_mem_req && !i_mem_ready;
        w_mult_busy    = !i_reset && (r_state == StMult);
        w_hold         = w_mult_busy || w_mem_wait;
        // Hold beats flush; a held branch is remembered and flushed later.
        w_branch_flush = !i_reset && (i_ex_branch_taken || r_branch_pending) && !w_hold;
        // A flushing branch squashes the dependent instruction, so no stall needed.
        w_load_use     = !i_reset && w_hz && (r_state == StIdle) && !w_branch_flush;
        w_stall        = w_load_use || w_mult_busy || w_mem_wait;
        w_any_req      = w_stall || w_branch_flush;
    end

    // Pipeline control outputs.
    always_comb begin
        o_load_use_req     = w_load_use;
        o_mult_busy_req    = w_mult_busy;
        o_mem_wait_req     = w_mem_wait;
        o_branch_flush_req = w_branch_flush;
        o_pc_write         = w_hold ? 1'b0 : (!w_stall || w_branch_flush);
        o_ifid_write       = !w_stall;
        o_idex_bubble      = w_load_use || w_branch_flush;
        o_ifid_flush       = w_branch_flush;
        o_stall_cycles     = r_stall_cycles;
    end

    // Multiply FSM next state; the countdown freezes while memory is stalling.
    always_comb begin
        w_state_next    = r_state;
        w_mult_cnt_next = r_mult_cnt;
        unique case (r_state)
            StIdle: begin
                if (i_ex_mult_start) begin
                    w_state_next    = StMult;
                    w_mult_cnt_next = MultLoad;
                end
            end
            StMult: begin
                if (!w_mem_wait) begin
                    if (r_mult_cnt == 4'd1) begin
                        w_state_next    = StIdle;
                        w_mult_cnt_next = 4'd0;
                    end else begin
                        w_mult_cnt_next = r_mult_cnt - 4'd1;
                    end
                end
            end
            default: begin
                w_state_next    = StIdle;
                w_mult_cnt_next = 4'd0;
            end
        endcase
    end

    // Pending-branch flag and saturating stall counter next values.
    always_comb begin
        w_branch_pending_next = r_branch_pending;
        if (w_branch_flush) begin
            w_branch_pending_next = 1'b0;
        end else if (i_ex_branch_taken && w_hold) begin
            w_branch_pending_next = 1'b1;
        end

        w_stall_cycles_next = r_stall_cycles;
        if (w_any_req && (r_stall_cycles != CntMax)) begin
            w_stall_cycles_next = r_stall_cycles + CNT_W'(1);
        end
    end

    // State registers with synchronous, dominant reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state          <= StIdle;
            r_mult_cnt       <= 4'd0;
            r_branch_pending <= 1'b0;
            r_stall_cycles   <= '0;
        end else begin
            r_state          <= w_state_next;
            r_mult_cnt       <= w_mult_cnt_next;
            r_branch_pending <= w_branch_pending_next;
            r_stall_cycles   <= w_stall_cycles_next;
        end
    end

endmodule

// File: tb/tb_stall_req_unit.sv
// Self-checking bench for stall_req_unit: a cycle model pushes expected
// outputs to a queue as each cycle's inputs are driven, and the queue is
// popped and compared against the DUT at the following falling edge.
module tb_stall_req_unit;

    localparam int MultCycles = 4;
    localparam int CntW       = 4;
    localparam int CntMax     = (1 << CntW) - 1;

    typedef struct packed {
        logic            lu;
        logic            mb;
        logic            mw;
        logic            bf;
        logic            pcw;
        logic            ifw;
        logic            bub;
        logic            fl;
        logic            cnt_valid;
        logic [CntW-1:0] cnt;
    } exp_t;

    logic            clk;
    logic            rst;
    logic [4:0]      id_rs;
    logic [4:0]      id_rt;
    logic            id_uses_rt;
    logic [4:0]      ex_rd;
    logic            ex_mem_read;
    logic            ex_mult_start;
    logic            ex_branch_taken;
    logic            mem_req;
    logic            mem_ready;
    logic            load_use_req;
    logic            mult_busy_req;
    logic            mem_wait_req;
    logic            branch_flush_req;
    logic            pc_write;
    logic            ifid_write;
    logic            idex_bubble;
    logic            ifid_flush;
    logic [CntW-1:0] stall_cycles;

    int n_checks = 0;
    int n_errors = 0;

    exp_t q[$];

    // Reference model state.
    int              m_left    = 0;
    logic            m_pending = 1'b0;
    logic [CntW-1:0] m_cnt     = '0;
    logic            m_valid   = 1'b0;

    stall_req_unit #(
        .MULT_CYCLES(MultCycles),
        .CNT_W      (CntW)
    ) dut (
        .i_clk             (clk),
        .i_reset           (rst),
        .i_id_rs           (id_rs),
        .i_id_rt           (id_rt),
        .i_id_uses_rt      (id_uses_rt),
        .i_ex_rd           (ex_rd),
        .i_ex_mem_read     (ex_mem_read),
        .i_ex_mult_start   (ex_mult_start),
        .i_ex_branch_taken (ex_branch_taken),
        .i_mem_req         (mem_req),
        .i_mem_ready       (mem_ready),
        .o_load_use_req    (load_use_req),
        .o_mult_busy_req   (mult_busy_req),
        .o_mem_wait_req    (mem_wait_req),
        .o_branch_flush_req(branch_flush_req),
        .o_pc_write        (pc_write),
        .o_ifid_write      (ifid_write),
        .o_idex_bubble     (idex_bubble),
        .o_ifid_flush      (ifid_flush),
        .o_stall_cycles    (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clr_inputs();
        rst             = 1'b0;
        id_rs           = 5'd0;
        id_rt           = 5'd0;
        id_uses_rt      = 1'b0;
        ex_rd           = 5'd0;
        ex_mem_read     = 1'b0;
        ex_mult_start   = 1'b0;
        ex_branch_taken = 1'b0;
        mem_req         = 1'b0;
        mem_ready       = 1'b1;
    endtask

    task automatic rand_inputs();
        id_rs           = 5'($urandom_range(0, 3));
        id_rt           = 5'($urandom_range(0, 3));
        id_uses_rt      = 1'($urandom);
        ex_rd           = 5'($urandom_range(0, 3));
        ex_mem_read     = 1'($urandom);
        ex_mult_start   = ($urandom_range(0, 7) == 0);
        ex_branch_taken = ($urandom_range(0, 5) == 0);
        mem_req         = 1'($urandom);
        mem_ready       = ($urandom_range(0, 3) != 0);
    endtask

    // Model the current cycle, queue the expectation, compare at the falling
    // edge, then advance to just after the next rising edge.
    task automatic tick();
        exp_t e;
        logic mw, mb, hold, bf, hz, lu, stall;
        e.cnt       = m_cnt;
        e.cnt_valid = m_valid;
        if (rst) begin
            e.lu = 0; e.mb = 0; e.mw = 0; e.bf = 0;
            e.pcw = 1; e.ifw = 1; e.bub = 0; e.fl = 0;
            m_cnt     = '0;
            m_valid   = 1'b1;
            m_left    = 0;
            m_pending = 1'b0;
        end else begin
            mw    = mem_req && !mem_ready;
            mb    = (m_left > 0);
            hold  = mb || mw;
            bf    = (ex_branch_taken || m_pending) && !hold;
            hz    = ex_mem_read && (ex_rd != 0) &&
                    ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
            lu    = hz && !mb && !bf;
            stall = lu || mb || mw;
            e.lu  = lu;
            e.mb  = mb;
            e.mw  = mw;
            e.bf  = bf;
            e.pcw = hold ? 1'b0 : (!stall || bf);
            e.ifw = !stall;
            e.bub = lu || bf;
            e.fl  = bf;
            if ((stall || bf) && (int'(m_cnt) != CntMax)) m_cnt = m_cnt + 1'b1;
            if (bf) m_pending = 1'b0;
            else if (ex_branch_taken && hold) m_pending = 1'b1;
            if (mb) begin
                if (!mw) m_left = m_left - 1;
            end else if (ex_mult_start) begin
                m_left = MultCycles - 1;
            end
        end
        q.push_back(e);

        @(negedge clk);
        e = q.pop_front();
        check_eq("load_use_req", 32'(load_use_req), 32'(e.lu));
        check_eq("mult_busy_req", 32'(mult_busy_req), 32'(e.mb));
        check_eq("mem_wait_req", 32'(mem_wait_req), 32'(e.mw));
        check_eq("branch_flush_req", 32'(branch_flush_req), 32'(e.bf));
        check_eq("pc_write", 32'(pc_write), 32'(e.pcw));
        check_eq("ifid_write", 32'(ifid_write), 32'(e.ifw));
        check_eq("idex_bubble", 32'(idex_bubble), 32'(e.bub));
        check_eq("ifid_flush", 32'(ifid_flush), 32'(e.fl));
        if (e.cnt_valid) check_eq("stall_cycles", 32'(stall_cycles), 32'(e.cnt));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            rand_inputs();
            rst = 1'b1;
            tick();
        end
        clr_inputs();
    endtask

    initial begin
        clr_inputs();
        @(posedge clk);
        #1;

        // Reset with random inputs.
        do_reset(2);

        // Directed table: load-use variants, multiply with frozen countdown,
        // ignored restart, branch held behind the multiply.
        for (int c = 0; c < 32; c++) begin
            clr_inputs();
            case (c)
                1: begin ex_mem_read = 1; ex_rd = 5; id_rs = 5; end
                2: begin ex_mem_read = 1; ex_rd = 0; id_rs = 0; end
                3: begin ex_mem_read = 1; ex_rd = 7; id_rt = 7; id_uses_rt = 1; end
                4: begin ex_mem_read = 1; ex_rd = 7; id_rt = 7; id_rs = 3; end
                5: begin ex_mem_read = 1; ex_rd = 9; id_rs = 9; ex_branch_taken = 1; end
                7: begin mem_req = 1; mem_ready = 1; end
                10: ex_mult_start = 1;
                12: begin ex_mult_start = 1; mem_req = 1; mem_ready = 0; ex_branch_taken = 1; end
                13: begin mem_req = 1; mem_ready = 0; end
                14: begin ex_mem_read = 1; ex_rd = 4; id_rs = 4; end
                22: ex_mult_start = 1;
                23: begin ex_mem_read = 1; ex_rd = 2; id_rs = 2; end
                default: ;
            endcase
            tick();
        end

        // Reset mid-multiply abandons it.
        ex_mult_start = 1;
        tick();
        clr_inputs();
        tick();
        do_reset(1);
        for (int i = 0; i < 4; i++) tick();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            clr_inputs();
            rand_inputs();
            tick();
        end

        // Long memory wait drives the counter into saturation.
        do_reset(1);
        for (int i = 0; i < 20; i++) begin
            clr_inputs();
            mem_req   = 1;
            mem_ready = 0;
            tick();
        end
        clr_inputs();
        tick();
        check_eq("stall_cycles_sat", 32'(stall_cycles), 32'(CntMax));

        check_eq("queue_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
